// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a per-symbol code table, then matches each
// accepted stream bit against every loaded entry and emits the decoded symbol.
module huffman_decoder #(
    parameter int BIT_WIDTH  = 7,
    parameter int MAX_SYMBOL = 255,
    parameter int CODE_W     = 2*BIT_WIDTH+3,
    parameter int MAX_LEN    = 15
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 tbl_valid,
    input  logic [BIT_WIDTH:0]   tbl_symbol,
    input  logic [3:0]           tbl_length,
    input  logic [CODE_W-1:0]    tbl_code,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [BIT_WIDTH:0]   sym_out,
    output logic                 sym_valid,
    output logic [8:0]           tbl_count,
    output logic                 error,
    output logic [1:0]           state_dbg
);
    localparam int N_ENT = MAX_SYMBOL + 1;
    localparam int IDXW  = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DECODE = 2'd2, ERROR = 2'd3} state_t;

    state_t              state_q;
    logic [8:0]          tbl_count_q;
    logic [CODE_W-1:0]   acc_q;
    logic [4:0]          n_q;
    logic [BIT_WIDTH:0]  sym_out_q;
    logic                sym_valid_q;
    logic                error_q;
    logic                bit_ready_q;

    logic [BIT_WIDTH:0]  tbl_sym_q  [N_ENT];
    logic [3:0]          tbl_len_q  [N_ENT];
    logic [CODE_W-1:0]   tbl_code_q [N_ENT];

    logic [CODE_W-1:0]   acc_d;
    logic [4:0]          n_d;
    logic [CODE_W-1:0]   mask;
    logic                hit;
    logic [BIT_WIDTH:0]  hit_sym;
    logic                tbl_bad;
    logic                wr_en;

    assign tbl_bad = (int'(tbl_length) > MAX_LEN) ||
                     (tbl_length == 4'd0 && tbl_count_q != 9'd0) ||
                     (tbl_count_q == 9'(N_ENT));
    assign wr_en   = rst && !clear && tbl_valid && !tbl_bad &&
                     (state_q == IDLE || state_q == LOAD);

    // Match the shifted-in accumulator against every entry; scanning downward
    // lets the lowest matching index overwrite any higher one.
    always_comb begin
        acc_d   = {acc_q[CODE_W-2:0], bit_in};
        n_d     = n_q + 5'd1;
        mask    = (CODE_W'(1) << n_d) - CODE_W'(1);
        hit     = 1'b0;
        hit_sym = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (i < int'(tbl_count_q) && int'(tbl_len_q[i]) == int'(n_d) &&
                ((tbl_code_q[i] ^ acc_d) & mask) == '0) begin
                hit     = 1'b1;
                hit_sym = tbl_sym_q[i];
            end
        end
        if (tbl_count_q == 9'd1 && tbl_len_q[0] == 4'd0) begin
            hit     = 1'b1;
            hit_sym = tbl_sym_q[0];
        end
    end

    // Table storage carries no reset; tbl_count_q alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tbl_sym_q[tbl_count_q[IDXW-1:0]]  <= tbl_symbol;
            tbl_len_q[tbl_count_q[IDXW-1:0]]  <= tbl_length;
            tbl_code_q[tbl_count_q[IDXW-1:0]] <= tbl_code;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tbl_count_q <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            error_q     <= 1'b0;
            bit_ready_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            tbl_count_q <= '0;
            acc_q       <= '0;
            n_q         <= '0;
            sym_valid_q <= 1'b0;
            error_q     <= 1'b0;
            bit_ready_q <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (tbl_valid) begin
                        if (tbl_bad) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q     <= LOAD;
                            tbl_count_q <= tbl_count_q + 9'd1;
                        end
                    end else if (state_q == LOAD) begin
                        state_q     <= DECODE;
                        acc_q       <= '0;
                        n_q         <= '0;
                        bit_ready_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (bit_valid) begin
                        if (hit) begin
                            sym_out_q   <= hit_sym;
                            sym_valid_q <= 1'b1;
                            acc_q       <= '0;
                            n_q         <= '0;
                        end else if (int'(n_d) >= MAX_LEN) begin
                            state_q     <= ERROR;
                            error_q     <= 1'b1;
                            bit_ready_q <= 1'b0;
                        end else begin
                            acc_q <= acc_d;
                            n_q   <= n_d;
                        end
                    end
                end
                default: begin
                    bit_ready_q <= 1'b0;
                    error_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_q;
    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign tbl_count = tbl_count_q;
    assign error     = error_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder; decoded symbols are checked against a
// queue of expected symbols filled as completing bits are driven.
module tb_huffman_decoder;
    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        tbl_valid = 1'b0;
    logic [7:0]  tbl_symbol = '0;
    logic [3:0]  tbl_length = '0;
    logic [16:0] tbl_code = '0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [7:0]  sym_out;
    logic        sym_valid;
    logic [8:0]  tbl_count;
    logic        error;
    logic [1:0]  state_dbg;

    // Second instance with a shorter maximum code length, loaded separately.
    logic        clear7 = 1'b0;
    logic        tbl_valid7 = 1'b0;
    logic [3:0]  tbl_length7 = '0;
    logic        bit_ready7;
    logic [7:0]  sym_out7;
    logic        sym_valid7;
    logic [8:0]  tbl_count7;
    logic        error7;
    logic [1:0]  state_dbg7;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_sym;

    huffman_decoder dut (
        .clock(clock), .rst(rst), .clear(clear), .tbl_valid(tbl_valid),
        .tbl_symbol(tbl_symbol), .tbl_length(tbl_length), .tbl_code(tbl_code),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .sym_out(sym_out), .sym_valid(sym_valid), .tbl_count(tbl_count),
        .error(error), .state_dbg(state_dbg)
    );

    huffman_decoder #(.MAX_LEN(7)) dut7 (
        .clock(clock), .rst(rst), .clear(clear7), .tbl_valid(tbl_valid7),
        .tbl_symbol(8'h77), .tbl_length(tbl_length7), .tbl_code(17'h0),
        .bit_in(1'b0), .bit_valid(1'b0), .bit_ready(bit_ready7),
        .sym_out(sym_out7), .sym_valid(sym_valid7), .tbl_count(tbl_count7),
        .error(error7), .state_dbg(state_dbg7)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] s, input logic [3:0] l, input logic [16:0] c);
        tbl_valid  = 1'b1;
        tbl_symbol = s;
        tbl_length = l;
        tbl_code   = c;
        step();
        tbl_valid  = 1'b0;
    endtask

    task automatic end_load();
        tbl_valid = 1'b0;
        step();
    endtask

    task automatic send(input logic b, input logic push, input logic [7:0] s);
        bit_valid = 1'b1;
        bit_in    = b;
        if (push) exp_q.push_back(s);
        step();
        bit_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic load_abc();
        load(8'h41, 4'd1, 17'b0);
        load(8'h42, 4'd2, 17'b10);
        load(8'h43, 4'd2, 17'b11);
        end_load();
    endtask

    // Every sym_valid pulse must correspond to the oldest outstanding expectation.
    always @(negedge clock) begin
        if (sym_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_sym observed=%0h expected=none", sym_out);
            end
            if (exp_q.size() != 0) begin
                exp_sym = exp_q.pop_front();
                checks++;
                assert (sym_out === exp_sym) else begin
                    failures++;
                    $error("FAIL sym_out observed=%0h expected=%0h", sym_out, exp_sym);
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_state", state_dbg, 0);
        chk("rst_count", tbl_count, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym_out", sym_out, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", bit_ready, 0);
        rst = 1'b1;
        step();

        load_abc();
        chk("abc_count", tbl_count, 3);
        chk("abc_state", state_dbg, 2);
        chk("abc_ready", bit_ready, 1);
        send(1'b1, 1'b0, 8'h00);
        send(1'b0, 1'b1, 8'h42);
        send(1'b0, 1'b1, 8'h41);
        send(1'b1, 1'b0, 8'h00);
        send(1'b1, 1'b1, 8'h43);
        step();
        chk("abc_drained", exp_q.size(), 0);
        chk("abc_hold", sym_out, 8'h43);

        send(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_no_valid", sym_valid, 0);
        end
        send(1'b1, 1'b1, 8'h43);
        step();
        chk("gap_drained", exp_q.size(), 0);

        do_clear();
        chk("clr_state", state_dbg, 0);
        chk("clr_count", tbl_count, 0);
        load(8'h5A, 4'd0, 17'b0);
        end_load();
        chk("single_count", tbl_count, 1);
        for (int i = 0; i < 4; i++) send(i[0], 1'b1, 8'h5A);
        step();
        chk("single_drained", exp_q.size(), 0);

        do_clear();
        load(8'h41, 4'd2, 17'b00);
        end_load();
        for (int i = 0; i < 14; i++) send(1'b1, 1'b0, 8'h00);
        chk("len14_error", error, 0);
        chk("len14_ready", bit_ready, 1);
        send(1'b1, 1'b0, 8'h00);
        chk("len15_error", error, 1);
        chk("len15_ready", bit_ready, 0);
        chk("len15_state", state_dbg, 3);
        send(1'b0, 1'b0, 8'h00);
        chk("err_sticky", error, 1);
        tbl_valid = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        tbl_valid = 1'b0;
        chk("clr_prio_state", state_dbg, 0);
        chk("clr_prio_error", error, 0);
        chk("clr_prio_count", tbl_count, 0);

        tbl_valid7  = 1'b1;
        tbl_length7 = 4'd8;
        step();
        tbl_valid7  = 1'b0;
        chk("len_over_error", error7, 1);
        chk("len_over_state", state_dbg7, 3);
        chk("len_over_count", tbl_count7, 0);
        chk("len_over_ready", bit_ready7, 0);
        chk("len_over_sym", {sym_valid7, sym_out7}, 0);
        clear7 = 1'b1;
        step();
        clear7 = 1'b0;
        chk("dut7_clear", {error7, state_dbg7}, 0);

        for (int i = 0; i < 256; i++) begin
            tbl_valid  = 1'b1;
            tbl_symbol = i[7:0];
            tbl_length = 4'd15;
            tbl_code   = 17'(i);
            step();
        end
        chk("full_count", tbl_count, 256);
        chk("full_state", state_dbg, 1);
        chk("full_error", error, 0);
        step();
        tbl_valid = 1'b0;
        chk("ovf_error", error, 1);
        chk("ovf_state", state_dbg, 3);
        do_clear();

        load_abc();
        send(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        chk("abort_state", state_dbg, 0);
        chk("abort_count", tbl_count, 0);
        chk("abort_ready", bit_ready, 0);
        chk("abort_sym_out", sym_out, 0);
        step();
        rst = 1'b1;
        step();
        load_abc();
        send(1'b1, 1'b0, 8'h00);
        send(1'b0, 1'b1, 8'h42);
        step();
        chk("abort_sym_after", sym_out, 8'h42);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
